pe_ws_dbuf: RTL
===============

Name: pe_ws_dbuf

Overview:
Next-generation weight-stationary systolic processing element. Double-buffers its weight: a shadow register loads through a dedicated vertical weight chain while the active weight keeps computing, and a SWAP op promotes the shadow weight. The block adds valid-tagged activation and partial-sum streams, signed/unsigned mode, a parametrised accumulator width, and optional saturation with a sticky overflow flag. It tiles into an R x C array: activations flow left to right, partial sums and weights flow top to bottom.

Parameters:
WORD_WIDTH, 8, activation and weight width
ACC_WIDTH, 32, partial-sum width; must be >= 2*WORD_WIDTH+1
SATURATE, 0, 1 = clamp on overflow; 0 = wrap-around

Ports:
clk  in  1  global clock
reset_n  in  1  asynchronous active-low reset
op  in  2  00 IDLE, 01 COMPUTE, 10 SWAP, 11 CLEAR
mode_signed  in  1  1 = two's-complement operands and accumulation; static while op != IDLE
w_shift_en  in  1  load w_in into the shadow weight and forward it down the chain
w_in  in  WORD_WIDTH  weight chain input from the PE above
w_out  out  WORD_WIDTH  registered weight chain output to the PE below
a_in  in  WORD_WIDTH  activation from the left
a_valid_in  in  1  a_in valid
a_out  out  WORD_WIDTH  registered activation to the right
a_valid_out  out  1  registered a_valid_in
ps_in  in  ACC_WIDTH  partial sum from above
ps_valid_in  in  1  ps_in valid; when low, ps_in is treated as 0
ps_out  out  ACC_WIDTH  registered partial sum to below
ps_valid_out  out  1  ps_out valid
ovf_sticky  out  1  an overflow has occurred since reset, CLEAR or ovf_clr
ovf_clr  in  1  clears ovf_sticky
swap_err  out  1  one-cycle pulse: SWAP requested with empty shadow

Behaviour:
- Reset (async, reset_n=0): all outputs 0; active_w=0, shadow_w=0, active_vld=0, shadow_vld=0.
- Weight chain is independent of op, except CLEAR:
  - w_shift_en=1 -> shadow_w<=w_in, w_out<=w_in, shadow_vld<=1 (1-cycle chain latency).
  - w_shift_en=0 -> w_out holds.
- IDLE: a_valid_out<=0, ps_valid_out<=0; data outputs and weights hold.
- COMPUTE (1-cycle latency):
  - a_out<=a_in, a_valid_out<=a_valid_in.
  - If a_valid_in: ps_out<=f(ps_in_eff + ext(active_w*a_in)), ps_valid_out<=1.
  - Else: ps_out<=ps_in, ps_valid_out<=ps_valid_in (pass-through).
  - active_vld=0 -> product forced to 0.
- Arithmetic:
  - Product is 2*WORD_WIDTH wide, sign-extended to ACC_WIDTH if mode_signed, else zero-extended.
  - Sum is ACC_WIDTH wide.
  - Overflow, signed mode: operand signs equal and result sign differs.
  - Overflow, unsigned mode: carry out of bit ACC_WIDTH-1.
  - SATURATE=1: clamp to max/min of the active mode (unsigned min is not reachable).
  - SATURATE=0: wrap.
  - Either mode: overflow sets ovf_sticky, only on cycles where ps_valid_out is written 1.
- SWAP:
  - shadow_vld=1 -> active_w<=shadow_w, active_vld<=1, shadow_vld<=0.
  - shadow_vld=0 -> weights unchanged, swap_err=1 for one cycle.
  - Valid outputs are cleared for the cycle.
  - SWAP with w_shift_en=1 in the same cycle: active gets the OLD shadow, shadow gets w_in, shadow_vld stays 1.
- CLEAR: all weights, valids, data outputs and ovf_sticky <= 0. CLEAR overrides w_shift_en.
- ovf_clr and a new overflow in the same cycle: set wins.
- Reset mid-operation: immediate return to reset values; no partial result survives.
- swap_err is 0 in every cycle that is not a failed SWAP.

Decomposition:
- Shared header/package pe_defs: op encodings (PE_OP_IDLE/COMPUTE/SWAP/CLEAR), default widths.
- One combinational sub-module, pe_mac_unit (params WORD_WIDTH, ACC_WIDTH, SATURATE):
  - Inputs: w, a, ps, mode_signed.
  - Outputs: sum, ovf.
  - Contains the multiply, extension, add, overflow detection and clamp.
- pe_ws_dbuf holds the registers and op decode.

Test Plan:
- Reset: drive random inputs, assert reset_n=0 -> all outputs 0 immediately (asynchronous); after release, a COMPUTE with a=3, ps=10 gives ps_out=10 (no active weight).
- Basic MAC, unsigned, W=8, ACC=32: shift w_in=5, SWAP, then COMPUTE a=3, ps_in=10 -> next cycle ps_out=25, ps_valid_out=1, a_out=3.
- Signed vs unsigned: active_w=0xFE, a=3, ps=0:
  - mode_signed=1 -> ps_out=0xFFFFFFFA.
  - mode_signed=0 -> ps_out=762.
- Double buffer: active_w=5; during back-to-back COMPUTE (a=2, ps=0), shift in 7 -> ps_out stays 10 and w_out=7 one cycle later; after SWAP, ps_out=14. SWAP again with no new shift -> swap_err pulse, ps_out stays 14.
- Overflow, signed, ps_in=0x7FFFFFFF, w=1, a=1:
  - SATURATE=1 -> ps_out=0x7FFFFFFF, ovf_sticky=1 until ovf_clr.
  - SATURATE=0 -> ps_out=0x80000000, ovf_sticky=1.
  - ovf_clr with a simultaneous overflow -> ovf_sticky stays 1.
- Simultaneous events: SWAP with w_shift_en=1 (shadow=9, w_in=4) -> active=9, shadow=4 and valid. CLEAR with w_shift_en=1 -> everything 0. Reset asserted mid-COMPUTE stream -> outputs 0 the same cycle.

Source files
------------

// File: rtl/pe_ws_dbuf_pkg.sv
// Shared definitions for the double-buffered weight-stationary PE:
// op encodings and default widths.
package pe_ws_dbuf_pkg;

  localparam int PE_WORD_WIDTH = 8;
  localparam int PE_ACC_WIDTH  = 32;

  typedef enum logic [1:0] {
    PE_OP_IDLE    = 2'b00,
    PE_OP_COMPUTE = 2'b01,
    PE_OP_SWAP    = 2'b10,
    PE_OP_CLEAR   = 2'b11
  } pe_op_e;

endpackage

// File: rtl/pe_ws_dbuf_if.sv
// Bundle of control, weight-chain, activation and partial-sum signals of one PE.
// The slave side is the PE itself; the master side is its environment.
interface pe_ws_dbuf_if #(
  parameter int WORD_WIDTH = 8,
  parameter int ACC_WIDTH  = 32
);
  import pe_ws_dbuf_pkg::*;

  pe_op_e                 op;
  logic                   mode_signed;
  logic                   w_shift_en;
  logic [WORD_WIDTH-1:0]  w_in;
  logic [WORD_WIDTH-1:0]  w_out;
  logic [WORD_WIDTH-1:0]  a_in;
  logic                   a_valid_in;
  logic [WORD_WIDTH-1:0]  a_out;
  logic                   a_valid_out;
  logic [ACC_WIDTH-1:0]   ps_in;
  logic                   ps_valid_in;
  logic [ACC_WIDTH-1:0]   ps_out;
  logic                   ps_valid_out;
  logic                   ovf_sticky;
  logic                   ovf_clr;
  logic                   swap_err;

  modport slave (
    input  op, mode_signed, w_shift_en, w_in, a_in, a_valid_in,
           ps_in, ps_valid_in, ovf_clr,
    output w_out, a_out, a_valid_out, ps_out, ps_valid_out,
           ovf_sticky, swap_err
  );

  modport master (
    output op, mode_signed, w_shift_en, w_in, a_in, a_valid_in,
           ps_in, ps_valid_in, ovf_clr,
    input  w_out, a_out, a_valid_out, ps_out, ps_valid_out,
           ovf_sticky, swap_err
  );

endinterface

// File: rtl/pe_ws_dbuf_mac_unit.sv
// Combinational multiply-accumulate: w*a extended to the accumulator width,
// added to ps, with overflow detection and optional clamping.
module pe_mac_unit #(
  parameter int WORD_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter bit SATURATE   = 1'b0
) (
  input  logic [WORD_WIDTH-1:0] w,
  input  logic [WORD_WIDTH-1:0] a,
  input  logic [ACC_WIDTH-1:0]  ps,
  input  logic                  mode_signed,
  output logic [ACC_WIDTH-1:0]  sum,
  output logic                  ovf
);

  localparam int PW = 2 * WORD_WIDTH;

  logic [PW-1:0]        w_prod_u;
  logic [PW-1:0]        w_prod_s;
  logic [PW-1:0]        w_prod;
  logic [ACC_WIDTH-1:0] w_ext;
  logic [ACC_WIDTH:0]   w_full;
  logic [ACC_WIDTH-1:0] w_raw;
  logic [ACC_WIDTH-1:0] w_clamp;
  logic                 w_ovf_s;

  // Operands are pre-extended to the product width so the low PW bits of
  // the multiply are exact in both signed and unsigned interpretation.
  assign w_prod_u = {{WORD_WIDTH{1'b0}}, w} * {{WORD_WIDTH{1'b0}}, a};
  assign w_prod_s = $unsigned($signed({{WORD_WIDTH{w[WORD_WIDTH-1]}}, w}) *
                              $signed({{WORD_WIDTH{a[WORD_WIDTH-1]}}, a}));
  assign w_prod   = mode_signed ? w_prod_s : w_prod_u;

  assign w_ext = mode_signed ? {{(ACC_WIDTH-PW){w_prod[PW-1]}}, w_prod}
                             : {{(ACC_WIDTH-PW){1'b0}}, w_prod};

  assign w_full = {1'b0, ps} + {1'b0, w_ext};
  assign w_raw  = w_full[ACC_WIDTH-1:0];

  assign w_ovf_s = (ps[ACC_WIDTH-1] == w_ext[ACC_WIDTH-1]) &&
                   (w_raw[ACC_WIDTH-1] != ps[ACC_WIDTH-1]);
  assign ovf     = mode_signed ? w_ovf_s : w_full[ACC_WIDTH];

  // Signed overflow direction follows the (shared) operand sign; unsigned
  // can only overflow upward.
  assign w_clamp = !mode_signed     ? {ACC_WIDTH{1'b1}} :
                   ps[ACC_WIDTH-1]  ? {1'b1, {(ACC_WIDTH-1){1'b0}}} :
                                      {1'b0, {(ACC_WIDTH-1){1'b1}}};

  assign sum = (SATURATE && ovf) ? w_clamp : w_raw;

endmodule

// File: rtl/pe_ws_dbuf.sv
// Weight-stationary systolic PE with a double-buffered weight: the shadow
// weight loads through the vertical chain while the active weight computes.
module pe_ws_dbuf
  import pe_ws_dbuf_pkg::*;
#(
  parameter int WORD_WIDTH = PE_WORD_WIDTH,
  parameter int ACC_WIDTH  = PE_ACC_WIDTH,
  parameter bit SATURATE   = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  pe_ws_dbuf_if.slave bus
);

  logic [WORD_WIDTH-1:0] r_active_w;
  logic [WORD_WIDTH-1:0] r_shadow_w;
  logic                  r_active_vld;
  logic                  r_shadow_vld;
  logic [WORD_WIDTH-1:0] r_w_out;
  logic [WORD_WIDTH-1:0] r_a_out;
  logic                  r_a_valid_out;
  logic [ACC_WIDTH-1:0]  r_ps_out;
  logic                  r_ps_valid_out;
  logic                  r_ovf_sticky;
  logic                  r_swap_err;

  logic [WORD_WIDTH-1:0] w_w_eff;
  logic [ACC_WIDTH-1:0]  w_ps_eff;
  logic [ACC_WIDTH-1:0]  w_sum;
  logic                  w_ovf;

  assign w_w_eff  = r_active_vld    ? r_active_w : '0;
  assign w_ps_eff = bus.ps_valid_in ? bus.ps_in  : '0;

  pe_mac_unit #(
    .WORD_WIDTH (WORD_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH),
    .SATURATE   (SATURATE)
  ) u_mac (
    .w           (w_w_eff),
    .a           (bus.a_in),
    .ps          (w_ps_eff),
    .mode_signed (bus.mode_signed),
    .sum         (w_sum),
    .ovf         (w_ovf)
  );

  // NOTE: every register here is a handful of flops, so all are reset; no
  // partial result may survive a mid-stream reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_active_w     <= '0;
      r_shadow_w     <= '0;
      r_active_vld   <= 1'b0;
      r_shadow_vld   <= 1'b0;
      r_w_out        <= '0;
      r_a_out        <= '0;
      r_a_valid_out  <= 1'b0;
      r_ps_out       <= '0;
      r_ps_valid_out <= 1'b0;
      r_ovf_sticky   <= 1'b0;
      r_swap_err     <= 1'b0;
    end else if (bus.op == PE_OP_CLEAR) begin
      r_active_w     <= '0;
      r_shadow_w     <= '0;
      r_active_vld   <= 1'b0;
      r_shadow_vld   <= 1'b0;
      r_w_out        <= '0;
      r_a_out        <= '0;
      r_a_valid_out  <= 1'b0;
      r_ps_out       <= '0;
      r_ps_valid_out <= 1'b0;
      r_ovf_sticky   <= 1'b0;
      r_swap_err     <= 1'b0;
    end else begin
      r_swap_err <= 1'b0;
      if (bus.ovf_clr) r_ovf_sticky <= 1'b0;

      case (bus.op)
        PE_OP_COMPUTE: begin
          r_a_out       <= bus.a_in;
          r_a_valid_out <= bus.a_valid_in;
          if (bus.a_valid_in) begin
            r_ps_out       <= w_sum;
            r_ps_valid_out <= 1'b1;
            if (w_ovf) r_ovf_sticky <= 1'b1;
          end else begin
            r_ps_out       <= bus.ps_in;
            r_ps_valid_out <= bus.ps_valid_in;
          end
        end
        PE_OP_SWAP: begin
          r_a_valid_out  <= 1'b0;
          r_ps_valid_out <= 1'b0;
          if (r_shadow_vld) begin
            r_active_w   <= r_shadow_w;
            r_active_vld <= 1'b1;
            r_shadow_vld <= 1'b0;
          end else begin
            r_swap_err <= 1'b1;
          end
        end
        default: begin
          r_a_valid_out  <= 1'b0;
          r_ps_valid_out <= 1'b0;
        end
      endcase

      // NOTE: non-blocking assignments let the last write win, so a shift in
      // the same cycle as a SWAP re-fills the shadow after the swap empties it.
      if (bus.w_shift_en) begin
        r_shadow_w   <= bus.w_in;
        r_shadow_vld <= 1'b1;
        r_w_out      <= bus.w_in;
      end
    end
  end

  assign bus.w_out        = r_w_out;
  assign bus.a_out        = r_a_out;
  assign bus.a_valid_out  = r_a_valid_out;
  assign bus.ps_out       = r_ps_out;
  assign bus.ps_valid_out = r_ps_valid_out;
  assign bus.ovf_sticky   = r_ovf_sticky;
  assign bus.swap_err     = r_swap_err;

endmodule
